// File: rtl/parking_request_sequencer.sv
// parking_request_sequencer
// Front end of the parking FSM. It debounces the entry/exit gate sensors,
// queues one pending request per sensor, and checks each request against
// the current occupancy. Each accepted request goes to the FSM as one
// single-cycle code, followed by an idle gap. Invalid requests are dropped
// with a one-cycle reject pulse.
module parking_request_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter_raw,
    input  logic       exit_raw,
    input  logic [1:0] exit_place_raw,
    input  logic [3:0] lot_state,
    output logic [3:0] fsm_in,
    output logic       busy,
    output logic       reject_pulse,
    output logic       full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       raw_vec;
    logic [1:0]       rise;          // bit 0 = enter, bit 1 = exit
    logic [1:0]       place_s;
    logic [1:0]       place_q;
    logic             pend_enter;
    logic             pend_exit;
    logic             served_exit;
    logic             clr_enter;
    logic             clr_exit;
    logic             exit_ok;
    logic             enter_ok;
    logic [CNT_W-1:0] gap_cnt;

    assign raw_vec  = {exit_raw, enter_raw};
    assign exit_ok  = lot_state[place_q];
    assign enter_ok = (lot_state != 4'b1111);
    assign busy     = (state != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic             raw_s;
            logic             deb;
            logic [CNT_W-1:0] cnt;

            // A rise happens on the edge where the disagreement run completes while the level is low.
            assign rise[gi] = (raw_s != deb) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) && !deb;

            // Sample the raw sensor, then flip the debounced level after a long enough run of disagreement.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    raw_s <= 1'b0;
                    deb   <= 1'b0;
                    cnt   <= '0;
                end else begin
                    raw_s <= raw_vec[gi];
                    if (raw_s == deb) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb <= ~deb;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Decide which pending flag is retired this cycle: a rejected request in IDLE, or the request just served by ISSUE.
    always_comb begin
        clr_enter = 1'b0;
        clr_exit  = 1'b0;
        case (state)
            IDLE: begin
                if (pend_exit) begin
                    clr_exit = !exit_ok;
                end else if (pend_enter) begin
                    clr_enter = !enter_ok;
                end
            end
            ISSUE: begin
                clr_exit  = served_exit;
                clr_enter = !served_exit;
            end
            default: begin
                clr_exit  = 1'b0;
                clr_enter = 1'b0;
            end
        endcase
    end

    // Pending request flags; a new debounced rise wins over a clear on the same edge.
    // An exit rise is dropped (place kept) only while the older exit request is still alive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            place_s    <= 2'b00;
            place_q    <= 2'b00;
            pend_enter <= 1'b0;
            pend_exit  <= 1'b0;
        end else begin
            place_s    <= exit_place_raw;
            pend_enter <= rise[0] | (pend_enter & ~clr_enter);
            pend_exit  <= rise[1] | (pend_exit & ~clr_exit);
            if (rise[1] && (!pend_exit || clr_exit)) begin
                place_q <= place_s;
            end
        end
    end

    // Sequencer FSM: exit has priority, each code lasts one cycle, then a fixed gap of zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fsm_in       <= 4'b0000;
            reject_pulse <= 1'b0;
            served_exit  <= 1'b0;
            gap_cnt      <= '0;
            full         <= 1'b0;
        end else begin
            full <= (lot_state == 4'b1111);
            case (state)
                IDLE: begin
                    fsm_in       <= 4'b0000;
                    reject_pulse <= 1'b0;
                    if (pend_exit) begin
                        if (exit_ok) begin
                            fsm_in      <= {2'b01, place_q};
                            served_exit <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            reject_pulse <= 1'b1;
                        end
                    end else if (pend_enter) begin
                        if (enter_ok) begin
                            fsm_in      <= 4'b1000;
                            served_exit <= 1'b0;
                            state       <= ISSUE;
                        end else begin
                            reject_pulse <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    fsm_in       <= 4'b0000;
                    reject_pulse <= 1'b0;
                    gap_cnt      <= CNT_W'(1);
                    state        <= GAP;
                end
                GAP: begin
                    fsm_in       <= 4'b0000;
                    reject_pulse <= 1'b0;
                    if (gap_cnt == CNT_W'(GAP_CYCLES)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    fsm_in       <= 4'b0000;
                    reject_pulse <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_request_sequencer.sv
// Self-checking bench for parking_request_sequencer: directed scenarios plus
// random sensor traffic, all compared every cycle against a behavioural model
// of the request rules (run-length debounce, pending flags, busy window).
module tb_parking_request_sequencer;

    localparam int D = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter_raw;
    logic       exit_raw;
    logic [1:0] exit_place_raw;
    logic [3:0] lot_state;
    logic [3:0] fsm_in;
    logic       busy;
    logic       reject_pulse;
    logic       full;

    parking_request_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .GAP_CYCLES     (G),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enter_raw     (enter_raw),
        .exit_raw      (exit_raw),
        .exit_place_raw(exit_place_raw),
        .lot_state     (lot_state),
        .fsm_in        (fsm_in),
        .busy          (busy),
        .reject_pulse  (reject_pulse),
        .full          (full)
    );

    always #5 clk = ~clk;

    // Reference model state: index 0 = enter sensor, 1 = exit sensor.
    int       m_run [2];
    bit       m_s   [2];
    bit       m_deb [2];
    bit       m_pend[2];
    bit [1:0] m_sp;
    bit [1:0] m_place;
    int       m_rem;          // busy cycles still to run after an issued code
    bit       m_served_x;
    logic [3:0] e_fsm;
    bit       e_rej;
    bit       e_full;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int obs_issue = 0;
    int obs_rej   = 0;
    int obs_busy  = 0;
    int first_issue = -1;
    logic [3:0] codes[$];
    int         code_cyc[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_s[i] = 0; m_deb[i] = 0; m_pend[i] = 0;
        end
        m_sp = 0; m_place = 0; m_rem = 0; m_served_x = 0;
        e_fsm = 4'b0000; e_rej = 0; e_full = 0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        bit rise[2];
        bit clr[2];
        for (int i = 0; i < 2; i++) begin
            rise[i] = 0;
            clr[i]  = 0;
            // debounce: level flips after D consecutive samples that disagree with it
            if (m_s[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_deb[i] = !m_deb[i];
                    m_run[i] = 0;
                    rise[i]  = m_deb[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        e_fsm = 4'b0000;
        e_rej = 0;
        if (m_rem == 0) begin
            if (m_pend[1]) begin
                if (lot_state[m_place]) begin
                    e_fsm = {2'b01, m_place}; m_rem = 1 + G; m_served_x = 1;
                end else begin
                    e_rej = 1; clr[1] = 1;
                end
            end else if (m_pend[0]) begin
                if (lot_state != 4'b1111) begin
                    e_fsm = 4'b1000; m_rem = 1 + G; m_served_x = 0;
                end else begin
                    e_rej = 1; clr[0] = 1;
                end
            end
        end else begin
            if (m_rem == 1 + G) clr[m_served_x ? 1 : 0] = 1;
            m_rem--;
        end
        if (rise[1] && (!m_pend[1] || clr[1])) m_place = m_sp;
        for (int i = 0; i < 2; i++) m_pend[i] = rise[i] | (m_pend[i] & !clr[i]);
        m_s[0] = enter_raw;
        m_s[1] = exit_raw;
        m_sp   = exit_place_raw;
        e_full = (lot_state == 4'b1111);
    endtask

    // Advance one clock, update the model, and compare all outputs just after the edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        cyc++;
        #1;
        if (e_fsm != 0) $display("cycle %0d: issue fsm_in=%b (lot=%b)", cyc, e_fsm, lot_state);
        if (e_rej)      $display("cycle %0d: reject (lot=%b)", cyc, lot_state);
        check("fsm_in", 8'(fsm_in), 8'(e_fsm));
        check("busy", 8'(busy), 8'(m_rem > 0));
        check("reject_pulse", 8'(reject_pulse), 8'(e_rej));
        check("full", 8'(full), 8'(e_full));
        if (fsm_in != 0) begin
            obs_issue++;
            codes.push_back(fsm_in);
            code_cyc.push_back(cyc);
            if (first_issue < 0) first_issue = cyc;
        end
        if (reject_pulse) obs_rej++;
        if (busy) obs_busy++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_obs();
        obs_issue = 0; obs_rej = 0; obs_busy = 0; first_issue = -1;
        codes.delete(); code_cyc.delete();
    endtask

    initial begin
        int c0;
        int hold_e;
        int hold_x;
        bit seen;

        rst = 1'b1; enter_raw = 0; exit_raw = 0; exit_place_raw = 0; lot_state = 4'b0000;
        model_reset();
        #1;
        check("reset fsm_in", 8'(fsm_in), 8'h0);
        check("reset busy", 8'(busy), 8'h0);
        steps(2);
        rst = 1'b0;
        steps(3);

        // 1: single enter, latency and busy window
        clear_obs();
        lot_state = 4'b0000;
        enter_raw = 1; c0 = cyc;
        steps(10);
        enter_raw = 0;
        steps(12);
        check("t1 issue count", 8'(obs_issue), 8'd1);
        check("t1 latency", 8'(first_issue - c0), 8'(D + 2));
        check("t1 busy cycles", 8'(obs_busy), 8'(1 + G));

        // 2: bouncing enter never qualifies
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            enter_raw = ~enter_raw;
            step();
        end
        enter_raw = 0;
        steps(12);
        check("t2 issue count", 8'(obs_issue), 8'd0);
        check("t2 reject count", 8'(obs_rej), 8'd0);

        // 3: valid exit to spot 2, then invalid exit from empty spot 1
        clear_obs();
        lot_state = 4'b0101; exit_place_raw = 2'b10; exit_raw = 1;
        steps(8);
        exit_raw = 0;
        steps(10);
        check("t3a issue count", 8'(obs_issue), 8'd1);
        if (codes.size() > 0) check("t3a code", 8'(codes[0]), 8'b0110);
        clear_obs();
        exit_place_raw = 2'b01; exit_raw = 1;
        steps(8);
        exit_raw = 0;
        steps(10);
        check("t3b issue count", 8'(obs_issue), 8'd0);
        check("t3b reject count", 8'(obs_rej), 8'd1);

        // 4: simultaneous enter and exit, exit first, enter after the gap
        clear_obs();
        lot_state = 4'b0001; exit_place_raw = 2'b00;
        enter_raw = 1; exit_raw = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (fsm_in == 4'b0100) lot_state = 4'b0000;
            if (i == 8) begin enter_raw = 0; exit_raw = 0; end
        end
        check("t4 issue count", 8'(obs_issue), 8'd2);
        if (codes.size() == 2) begin
            check("t4 first code", 8'(codes[0]), 8'b0100);
            check("t4 second code", 8'(codes[1]), 8'b1000);
            check("t4 code spacing", 8'(code_cyc[1] - code_cyc[0]), 8'(G + 2));
        end

        // 5: full lot rejects enter
        clear_obs();
        lot_state = 4'b1111; enter_raw = 1;
        steps(8);
        enter_raw = 0;
        steps(8);
        check("t5 reject count", 8'(obs_rej), 8'd1);
        check("t5 issue count", 8'(obs_issue), 8'd0);
        check("t5 full", 8'(full), 8'd1);

        // 6: reset during ISSUE
        clear_obs();
        lot_state = 4'b0000; enter_raw = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (e_fsm != 0) seen = 1;
        end
        check("t6 issue reached", 8'(seen), 8'd1);
        rst = 1'b1;
        #1;
        check("t6 async fsm_in", 8'(fsm_in), 8'h0);
        check("t6 async busy", 8'(busy), 8'h0);
        enter_raw = 0;
        steps(2);
        rst = 1'b0;
        clear_obs();
        steps(15);
        check("t6 no issue after reset", 8'(obs_issue), 8'd0);

        // random traffic
        hold_e = 0; hold_x = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_e == 0) begin enter_raw = 1'($urandom_range(0, 1)); hold_e = $urandom_range(1, 9); end
            if (hold_x == 0) begin
                exit_raw = 1'($urandom_range(0, 1)); hold_x = $urandom_range(1, 9);
                exit_place_raw = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 19) == 0) lot_state = 4'($urandom_range(0, 15));
            hold_e--; hold_x--;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
